// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and address helpers for the
// instruction-memory responder.
//   state_e      : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       : instruction word width
//   DEF_*        : default parameter values for imem_responder
//   word_index() : byte address -> word index
//   addr_err()   : misaligned or out-of-range fetch address
package imem_pkg;

  localparam int WORD_W          = 32;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DEPTH_WORDS = 64;
  localparam int DEF_LATENCY     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Callers zero-extend their ADDR_W-bit address to 32 bits.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || (word_index(addr) >= 32'(depth));
  endfunction

endpackage

// File: rtl/imem_word_array.sv
// imem_word_array: DEPTH_WORDS x 32-bit program storage.
//   clk     in  clock
//   wr_en   in  write strobe (already qualified by the load handshake)
//   wr_idx  in  word index to write; out-of-range writes are dropped
//   wr_data in  word to write
//   rd_idx  in  word index to read (asynchronous read)
//   rd_data out word at rd_idx; 0 for an out-of-range index
module imem_word_array
  import imem_pkg::*;
#(
  parameter int IDX_W       = 6,
  parameter int DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = 32'(wr_idx) < 32'(DEPTH_WORDS);
  assign rd_in_range = 32'(rd_idx) < 32'(DEPTH_WORDS);

  // NOTE: the storage has no reset branch; program words must survive a
  // responder reset, and a reset loop over the array would also stop it
  // mapping onto RAM. Sequential state is always written with <= so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem_q[wr_idx[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_in_range ? mem_q[rd_idx[AW-1:0]] : '0;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: serves 32-bit instruction fetches over a valid/ready
// request/response handshake with a fixed LATENCY, plus a side load port
// for writing program words while idle.
//   clk, reset         clock; synchronous active-high reset
//   req_valid/ready    fetch request handshake, req_addr = byte PC
//   rsp_valid/ready    response handshake, rsp_data word, rsp_err flag
//   load_en/ready      program-word write; load_addr (byte), load_data
//   fetch_count        completed response handshakes (wraps at 16 bits)
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              load_en,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic [15:0]       fetch_count
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic [IDX_W-1:0]  req_idx;
  logic              req_err;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [WORD_W-1:0] rd_data;
  logic              mem_wr_en;

  assign req_idx  = IDX_W'(word_index(32'(req_addr)));
  assign req_err  = addr_err(32'(req_addr), DEPTH_WORDS);
  assign load_idx = IDX_W'(word_index(32'(load_addr)));

  // The array is read at the index about to be captured into the response
  // register: straight from the request when LATENCY==1 skips WAIT,
  // otherwise from the index latched at acceptance.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

  imem_word_array #(
    .IDX_W       (IDX_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_idx  (load_idx),
    .wr_data (load_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    err_d         = err_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    fetch_count_d = fetch_count_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    load_ready    = 1'b0;
    mem_wr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready  = 1'b1;
        // A pending request always wins over a load in the same cycle.
        load_ready = ~req_valid;
        mem_wr_en  = load_en & ~req_valid;
        if (req_valid) begin
          idx_d = req_idx;
          err_d = req_err;
          cnt_d = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            rsp_err_d  = req_err;
            rsp_data_d = req_err ? '0 : rd_data;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          rsp_err_d  = err_q;
          rsp_data_d = err_q ? '0 : rd_data;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d       = IDLE;
          fetch_count_d = fetch_count_q + 16'd1;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed self-checking bench for imem_responder.
// DUT a: ADDR_W=8, DEPTH_WORDS=32, LATENCY=2 (handshake, stall, errors,
//        load priority, reset behaviour).
// DUT b: ADDR_W=8, DEPTH_WORDS=64, LATENCY=1 (fetch_count wrap).
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic        load_en, load_ready;
  logic [7:0]  req_addr, load_addr;
  logic [31:0] rsp_data, load_data;
  logic [15:0] fetch_count;

  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic        load_en_b, load_ready_b;
  logic [7:0]  req_addr_b, load_addr_b;
  logic [31:0] rsp_data_b, load_data_b;
  logic [15:0] fetch_count_b;

  int n_chk  = 0;
  int n_fail = 0;

  imem_responder #(.ADDR_W(8), .DEPTH_WORDS(32), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .load_en(load_en), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .fetch_count(fetch_count)
  );

  imem_responder #(.ADDR_W(8), .DEPTH_WORDS(64), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .load_en(load_en_b), .load_ready(load_ready_b), .load_addr(load_addr_b), .load_data(load_data_b),
    .fetch_count(fetch_count_b)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one program word through the load port, waiting (bounded) for load_ready.
  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    logic done;
    done      = 1'b0;
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      done = load_ready;
      step();
    end
    load_en = 1'b0;
    check("load taken", {31'd0, done}, 32'd1);
  endtask

  // Full fetch on dut_a with rsp_ready=1; checks latency, data and error.
  task automatic fetch(input string tag, input logic [7:0] addr,
                       input logic [31:0] exp_data, input logic exp_err);
    int lat;
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    req_addr  = 8'hFF;  // must be ignored after acceptance
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " data"}, rsp_data, exp_data);
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0; req_addr  = '0; rsp_ready = 1'b0;
    load_en   = 1'b0; load_addr = '0; load_data = '0;
    req_valid_b = 1'b0; req_addr_b  = '0; rsp_ready_b = 1'b0;
    load_en_b   = 1'b0; load_addr_b = '0; load_data_b = '0;
    step();
    step();
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset fetch_count", {16'd0, fetch_count}, 32'd0);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    step();

    load(8'h00, 32'h2008_0005);
    load(8'h04, 32'h0000_0000);
    load(8'h7C, 32'hCAFE_F00D);

    // Basic fetch, rsp_valid first at T+2.
    req_valid = 1'b1; req_addr = 8'h00; rsp_ready = 1'b1;
    #1;
    check("t1 req_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("t1 rsp_valid T+1", {31'd0, rsp_valid}, 32'd0);
    step();
    check("t1 rsp_valid T+2", {31'd0, rsp_valid}, 32'd1);
    check("t1 rsp_data", rsp_data, 32'h2008_0005);
    check("t1 rsp_err", {31'd0, rsp_err}, 32'd0);
    check("t1 req_ready in RESP", {31'd0, req_ready}, 32'd0);
    step();
    check("t1 fetch_count", {16'd0, fetch_count}, 32'd1);
    check("t1 rsp_valid after", {31'd0, rsp_valid}, 32'd0);
    check("t1 rsp_data cleared", rsp_data, 32'd0);

    // Stalled response for 5 cycles, handshake on the 6th.
    req_valid = 1'b1; req_addr = 8'h04; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0; req_addr = 8'h00;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2 stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("t2 stall rsp_data", rsp_data, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("t2 hs rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t2 hs req_ready", {31'd0, req_ready}, 32'd0);
    step();
    check("t2 after req_ready", {31'd0, req_ready}, 32'd1);
    check("t2 after rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t2 fetch_count", {16'd0, fetch_count}, 32'd2);

    // Error and boundary addresses.
    fetch("t3 misaligned", 8'h06, 32'd0, 1'b1);
    check("t3 rsp_err cleared", {31'd0, rsp_err}, 32'd0);
    fetch("t3 out of range", 8'h80, 32'd0, 1'b1);
    fetch("t3 last word", 8'h7C, 32'hCAFE_F00D, 1'b0);
    check("t3 fetch_count", {16'd0, fetch_count}, 32'd5);

    // Request beats a load in the same cycle; held load lands afterwards.
    req_valid = 1'b1; req_addr = 8'h00; rsp_ready = 1'b0;
    load_en = 1'b1; load_addr = 8'h08; load_data = 32'hDEAD_BEEF;
    #1;
    check("t4 load_ready with req", {31'd0, load_ready}, 32'd0);
    check("t4 req_ready with load", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    check("t4 load_ready WAIT", {31'd0, load_ready}, 32'd0);
    step();
    check("t4 rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t4 rsp_data", rsp_data, 32'h2008_0005);
    step();
    check("t4 stalled rsp_data", rsp_data, 32'h2008_0005);
    check("t4 load_ready RESP", {31'd0, load_ready}, 32'd0);
    rsp_ready = 1'b1;
    step();
    check("t4 load_ready IDLE", {31'd0, load_ready}, 32'd1);
    check("t4 fetch_count", {16'd0, fetch_count}, 32'd6);
    step();
    load_en = 1'b0;
    fetch("t4 readback", 8'h08, 32'hDEAD_BEEF, 1'b0);

    // Reset during WAIT drops the request; memory survives.
    req_valid = 1'b1; req_addr = 8'h04; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("t5 in WAIT", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5 fetch_count", {16'd0, fetch_count}, 32'd0);
    check("t5 req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5 no response", {31'd0, rsp_valid}, 32'd0);
    end
    fetch("t5 retained", 8'h00, 32'h2008_0005, 1'b0);
    check("t5 fetch_count after", {16'd0, fetch_count}, 32'd1);

    // fetch_count wrap on the LATENCY=1 instance: back-to-back fetches, 2 cycles each.
    req_valid_b = 1'b1; req_addr_b = 8'h00; rsp_ready_b = 1'b1;
    step();
    check("t6 latency1 rsp_valid", {31'd0, rsp_valid_b}, 32'd1);
    for (int i = 0; i < 131069; i++) step();
    check("t6 fetch_count 0xFFFF", {16'd0, fetch_count_b}, 32'h0000_FFFF);
    check("t6 idle rsp_valid", {31'd0, rsp_valid_b}, 32'd0);
    step();
    step();
    req_valid_b = 1'b0;
    check("t6 fetch_count wrap", {16'd0, fetch_count_b}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder that serves word fetch requests from the processor's fetch side over a valid/ready request/response handshake.
- Fetch address is the byte PC (low ADDR_W bits).
- Responds after a fixed programmable latency with the 32-bit instruction word or an error flag.
- A side load port lets the bench or boot logic write program words while the responder is idle.

Parameters:
- ADDR_W, 8: byte-address width of req_addr and load_addr.
- DEPTH_WORDS, 64: number of 32-bit words stored; must be <= 2^(ADDR_W-2).
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address of the instruction.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  requester accepts the response.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  misaligned or out-of-range address.
- load_en  in  1  write program word.
- load_ready  out  1  load write will be taken this cycle.
- load_addr  in  ADDR_W  byte address of word to write; bits [1:0] ignored.
- load_data  in  32  word to write.
- fetch_count  out  16  completed response handshakes; wraps 0xFFFF->0x0000.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0, fetch_count=0.
  - Memory contents are NOT cleared by reset.
  - Reset mid-operation discards any outstanding request; no response is issued for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready (cycle T), latch the word index req_addr[ADDR_W-1:2] and the error condition.
  - Error condition: req_addr[1:0]!=0, or index >= DEPTH_WORDS.
  - Load cnt=LATENCY-1. Next state is WAIT if LATENCY>1, else RESP.
- WAIT:
  - req_ready=0; cnt decrements each cycle.
  - When cnt reaches 1, move to RESP.
  - rsp_valid therefore first rises at cycle T+LATENCY.
- RESP:
  - rsp_valid=1.
  - rsp_data = mem[index] if no error; rsp_data=0 and rsp_err=1 if error.
  - rsp_data and rsp_err are registered and stable while rsp_valid=1 and rsp_ready=0. The array read is captured on entry to RESP.
  - On rsp_valid & rsp_ready: fetch_count += 1 and next state is IDLE.
  - rsp_valid, rsp_data and rsp_err return to 0 the following cycle.
- No same-cycle re-accept: req_ready is 0 in the cycle the response handshakes. Minimum request spacing is LATENCY+1 cycles.
- Load port:
  - load_ready = (state==IDLE) & ~req_valid. Requests have priority over loads.
  - When load_en & load_ready, write mem[load_addr[ADDR_W-1:2]] <= load_data at that edge.
  - Out-of-range load index: write dropped silently.
  - load_en while load_ready=0: write dropped. The loader must hold load_en until it sees load_ready.
- Load/read ordering: a word written at edge E is visible to a request accepted at edge E+1 or later.
- Reads of never-written words return an undefined value; the bench does not check them.
- Request inputs are sampled only at acceptance, so changing req_addr during WAIT or RESP has no effect.

Decomposition:
- Package imem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - WORD_W=32
  - default ADDR_W, DEPTH_WORDS and LATENCY constants
  - function word_index(addr)
  - function addr_err(addr, depth)
- One sub-module, imem_word_array: DEPTH_WORDS x 32 storage with one synchronous write port and one read port (index in, data out). The FSM, latency counter, error logic and fetch_count stay in imem_responder.

Test Plan:
- Load mem[0]=0x20080005 and mem[1]=0x00000000. Request addr 0x00 at T with rsp_ready=1 → rsp_valid first at T+2, rsp_data=0x20080005, rsp_err=0, fetch_count=1.
- Request addr 0x04 with rsp_ready held 0 for 5 cycles → rsp_valid and rsp_data stay stable 5 cycles. Handshake on the 6th cycle; req_ready=0 that cycle and 1 the next.
- Request addr 0x06 (misaligned) → rsp_err=1, rsp_data=0x00000000. With DEPTH_WORDS=32, addr 0x80 → rsp_err=1.
- Assert load_en (addr 0x08, data 0xDEADBEEF) and req_valid in the same IDLE cycle → load_ready=0 and the request is accepted. Hold load_en → write lands after the response completes. A later fetch of 0x08 returns 0xDEADBEEF.
- Assert reset during WAIT → next cycle state IDLE, rsp_valid=0, fetch_count=0, no response for the dropped request. A subsequent fetch of 0x00 still returns 0x20080005 (memory retained).
- Preload fetch_count to 0xFFFF via 65535 fetches (LATENCY=1 build), then one more handshake → fetch_count=0x0000.
